// File: rtl/accelerator_convolutional_fnn_input_loader_if.sv
// Host/FNN handshake bundle for the FNN input loader.
// master = host/FNN side, slave = loader side.
interface accelerator_convolutional_fnn_input_loader_if #(
  parameter int DATA_SIZE = 64
);
  logic                 START;
  logic                 READY;
  logic [DATA_SIZE-1:0] SIZE_X_IN;
  logic [DATA_SIZE-1:0] SIZE_L_IN;
  logic                 X_IN_ENABLE;
  logic [DATA_SIZE-1:0] X_IN;
  logic                 X_IN_ACCEPT;
  logic                 X_OUT_ENABLE;
  logic                 X_OUT_READY;
  logic [DATA_SIZE-1:0] X_OUT;
  logic [DATA_SIZE-1:0] X_OUT_INDEX;
  logic [DATA_SIZE-1:0] L_OUT_INDEX;
  logic                 X_OUT_LAST;

  modport master (
    output START, SIZE_X_IN, SIZE_L_IN, X_IN_ENABLE, X_IN, X_OUT_READY,
    input  READY, X_IN_ACCEPT, X_OUT_ENABLE, X_OUT, X_OUT_INDEX, L_OUT_INDEX, X_OUT_LAST
  );

  modport slave (
    input  START, SIZE_X_IN, SIZE_L_IN, X_IN_ENABLE, X_IN, X_OUT_READY,
    output READY, X_IN_ACCEPT, X_OUT_ENABLE, X_OUT, X_OUT_INDEX, L_OUT_INDEX, X_OUT_LAST
  );
endinterface

// File: rtl/accelerator_convolutional_fnn_input_loader.sv
// FNN input loader: captures one input vector from the host into a register
// buffer, then replays it size_l times towards the FNN with element/neuron tags.
module accelerator_convolutional_fnn_input_loader #(
  parameter int DATA_SIZE = 64,
  parameter int X         = 64,
  parameter int L         = 64
) (
  input logic CLK,
  input logic RST,
  accelerator_convolutional_fnn_input_loader_if.slave bus
);
  localparam int AW = (X > 1) ? $clog2(X) : 1;
  localparam logic [DATA_SIZE-1:0] ONE   = 1;
  localparam logic [DATA_SIZE-1:0] X_MAX = X;
  localparam logic [DATA_SIZE-1:0] L_MAX = L;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, FINISH} state_t;

  state_t state, state_nxt;

  logic [DATA_SIZE-1:0] size_x, size_l, wr_addr;
  logic [DATA_SIZE-1:0] x_idx, l_idx, x_data;
  logic                 x_vld, x_last;
  logic [DATA_SIZE-1:0] buffer [X];

  logic                 accept, done;
  logic                 in_xfer, out_xfer, load_done, x_wrap;
  logic [DATA_SIZE-1:0] sx_clamp, sl_clamp, x_idx_nxt, l_idx_nxt;
  logic [AW-1:0]        rd_addr;

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and state-decoded handshake outputs
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:   if (bus.START) state_nxt = (sx_clamp == '0 || sl_clamp == '0) ? FINISH : LOAD;
      LOAD:   begin
                accept = 1'b1;
                if (load_done) state_nxt = STREAM;
              end
      STREAM: if (out_xfer && x_last) state_nxt = FINISH;
      FINISH: begin
                done      = 1'b1;
                state_nxt = IDLE;
              end
      default: state_nxt = IDLE;
    endcase
  end

  // Size clamping, transfer qualifiers and replay index advance
  always_comb begin
    sx_clamp  = (bus.SIZE_X_IN > X_MAX) ? X_MAX : bus.SIZE_X_IN;
    sl_clamp  = (bus.SIZE_L_IN > L_MAX) ? L_MAX : bus.SIZE_L_IN;
    in_xfer   = bus.X_IN_ENABLE && accept;
    load_done = in_xfer && (wr_addr == size_x - ONE);
    out_xfer  = x_vld && bus.X_OUT_READY;
    x_wrap    = (x_idx == size_x - ONE);
    x_idx_nxt = x_wrap ? '0 : x_idx + ONE;
    l_idx_nxt = x_wrap ? l_idx + ONE : l_idx;
    rd_addr   = AW'(x_idx_nxt);
  end

  // Host write port into the vector buffer (contents not reset)
  always_ff @(posedge CLK) begin
    if (in_xfer) buffer[AW'(wr_addr)] <= bus.X_IN;
  end

  // Size latches, write pointer and registered FNN-side word
  always_ff @(posedge CLK) begin
    if (RST) begin
      size_x  <= '0;
      size_l  <= '0;
      wr_addr <= '0;
      x_idx   <= '0;
      l_idx   <= '0;
      x_data  <= '0;
      x_vld   <= 1'b0;
      x_last  <= 1'b0;
    end else begin
      if (state == IDLE && bus.START) begin
        size_x  <= sx_clamp;
        size_l  <= sl_clamp;
        wr_addr <= '0;
      end
      if (in_xfer) begin
        wr_addr <= wr_addr + ONE;
        if (load_done) begin
          // Buffer write lands on this same edge, so a 1-word vector bypasses it
          x_vld  <= 1'b1;
          x_data <= (size_x == ONE) ? bus.X_IN : buffer[0];
          x_idx  <= '0;
          l_idx  <= '0;
          x_last <= (size_x == ONE) && (size_l == ONE);
        end
      end
      if (out_xfer) begin
        if (x_last) begin
          x_vld  <= 1'b0;
          x_last <= 1'b0;
          x_idx  <= '0;
          l_idx  <= '0;
          x_data <= '0;
        end else begin
          x_idx  <= x_idx_nxt;
          l_idx  <= l_idx_nxt;
          x_data <= buffer[rd_addr];
          x_last <= (x_idx_nxt == size_x - ONE) && (l_idx_nxt == size_l - ONE);
        end
      end
    end
  end

  assign bus.READY        = done;
  assign bus.X_IN_ACCEPT  = accept;
  assign bus.X_OUT_ENABLE = x_vld;
  assign bus.X_OUT        = x_data;
  assign bus.X_OUT_INDEX  = x_idx;
  assign bus.L_OUT_INDEX  = l_idx;
  assign bus.X_OUT_LAST   = x_last;
endmodule

// File: tb/tb_accelerator_convolutional_fnn_input_loader.sv
// Bench for the FNN input loader: job table + random jobs checked against a
// replay-list model, plus hand sequences for reset and mid-stream reset.
module tb_accelerator_convolutional_fnn_input_loader;
  localparam int DW = 64, XD = 64, LD = 64;

  typedef struct {
    logic [63:0] data;
    int          xi;
    int          li;
    bit          last;
  } word_t;

  typedef struct {
    logic [63:0] sx;
    logic [63:0] sl;
    logic [63:0] base;
    logic [63:0] step;
    int          gap;
    int          bp;
    bit          stall;
    int          exp_acc;
    int          exp_out;
    string       name;
  } job_t;

  logic clk = 1'b0;
  logic rst;
  int   n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  accelerator_convolutional_fnn_input_loader_if #(.DATA_SIZE(DW)) bus ();

  accelerator_convolutional_fnn_input_loader #(.DATA_SIZE(DW), .X(XD), .L(LD)) dut (
    .CLK(clk),
    .RST(rst),
    .bus(bus)
  );

  task automatic chk(input bit ok, input string name, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endtask

  function automatic bit all_zero();
    return !bus.READY && !bus.X_IN_ACCEPT && !bus.X_OUT_ENABLE && !bus.X_OUT_LAST &&
           bus.X_OUT == '0 && bus.X_OUT_INDEX == '0 && bus.L_OUT_INDEX == '0;
  endfunction

  function automatic string out_str();
    return $sformatf("rdy=%0d acc=%0d en=%0d x=%0h xi=%0d li=%0d last=%0d", bus.READY,
                     bus.X_IN_ACCEPT, bus.X_OUT_ENABLE, bus.X_OUT, bus.X_OUT_INDEX,
                     bus.L_OUT_INDEX, bus.X_OUT_LAST);
  endfunction

  task automatic run_job(input job_t j);
    word_t       q[$];
    logic [63:0] w[$];
    word_t       h;
    int ex, el, acc, pops, cyc, rdy_cyc, last_acc, last_pop, first_en, stall_left;
    bit stall_done, extra, rdy;
    acc = 0; pops = 0; cyc = 0; rdy_cyc = -1; last_acc = -1; last_pop = -1;
    first_en = -1; stall_left = 0; stall_done = 0; extra = 0;
    // model: clamp sizes, then the replay list is every element for every neuron
    ex = (j.sx > 64'(XD)) ? XD : int'(j.sx);
    el = (j.sl > 64'(LD)) ? LD : int'(j.sl);
    for (int i = 0; i < ex; i++)
      w.push_back((j.base == 0 && j.step == 0) ? {$urandom, $urandom} : j.base + j.step * 64'(i));
    for (int l = 0; l < el; l++)
      for (int i = 0; i < ex; i++)
        q.push_back('{w[i], i, l, (l == el - 1) && (i == ex - 1)});

    @(negedge clk);
    bus.START = 1'b1; bus.SIZE_X_IN = j.sx; bus.SIZE_L_IN = j.sl;
    bus.X_IN_ENABLE = 1'b0; bus.X_OUT_READY = 1'b0;
    while (rdy_cyc < 0 && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      // START is ignored outside IDLE; sizes may change freely after START
      bus.START     = 1'($urandom_range(0, 1));
      bus.SIZE_X_IN = {$urandom, $urandom};
      bus.SIZE_L_IN = {$urandom, $urandom};
      if (bus.READY) begin
        rdy_cyc   = cyc;
        bus.START = 1'b1;
      end
      // FNN side
      if (bus.X_OUT_ENABLE) begin
        if (first_en < 0) first_en = cyc;
        if (q.size() == 0) begin
          chk(1'b0, {j.name, "/spurious_word"}, out_str());
          bus.X_OUT_READY = 1'b1;
        end else begin
          h = q[0];
          chk(bus.X_OUT == h.data && bus.X_OUT_INDEX == 64'(h.xi) &&
              bus.L_OUT_INDEX == 64'(h.li) && bus.X_OUT_LAST == h.last,
              {j.name, "/word"},
              $sformatf("got %s required x=%0h xi=%0d li=%0d last=%0d", out_str(),
                        h.data, h.xi, h.li, h.last));
          if (j.stall && !stall_done && bus.X_OUT_INDEX == 64'd2) begin
            stall_left = 3; stall_done = 1'b1;
          end
          if (stall_left > 0) begin
            rdy = 1'b0; stall_left--;
          end else rdy = ($urandom_range(0, 99) >= j.bp);
          bus.X_OUT_READY = rdy;
          if (rdy) begin
            void'(q.pop_front());
            pops++; last_pop = cyc;
          end
        end
      end else bus.X_OUT_READY = 1'($urandom_range(0, 1));
      // Host side
      if (bus.X_IN_ACCEPT) begin
        if (acc < ex && $urandom_range(0, 99) >= j.gap) begin
          bus.X_IN_ENABLE = 1'b1; bus.X_IN = w[acc];
          acc++; last_acc = cyc;
        end else begin
          if (acc >= ex) extra = 1'b1;
          bus.X_IN_ENABLE = 1'b0; bus.X_IN = {$urandom, $urandom};
        end
      end else begin
        // garbage outside LOAD must never reach the buffer
        bus.X_IN_ENABLE = 1'($urandom_range(0, 1)); bus.X_IN = {$urandom, $urandom};
      end
    end
    chk(rdy_cyc >= 0, {j.name, "/ready_seen"}, $sformatf("no READY within %0d cycles", cyc));
    chk(acc == j.exp_acc, {j.name, "/accepted"}, $sformatf("got %0d required %0d", acc, j.exp_acc));
    chk(pops == j.exp_out, {j.name, "/streamed"}, $sformatf("got %0d required %0d", pops, j.exp_out));
    chk(q.size() == 0, {j.name, "/queue_empty"}, $sformatf("left %0d required 0", q.size()));
    chk(!extra, {j.name, "/no_extra_accept"}, "X_IN_ACCEPT high after all words sent");
    if (ex > 0 && el > 0) begin
      chk(first_en == last_acc + 1, {j.name, "/first_word_latency"},
          $sformatf("got cycle %0d required %0d", first_en, last_acc + 1));
      chk(rdy_cyc == last_pop + 1, {j.name, "/ready_latency"},
          $sformatf("got cycle %0d required %0d", rdy_cyc, last_pop + 1));
    end else begin
      chk(first_en < 0, {j.name, "/no_stream"}, $sformatf("enable at cycle %0d", first_en));
      chk(rdy_cyc == 1, {j.name, "/ready_latency"}, $sformatf("got cycle %0d required 1", rdy_cyc));
    end
    // START was high in the READY cycle: must not start a new job
    @(negedge clk);
    bus.START = 1'b0; bus.X_IN_ENABLE = 1'b0; bus.X_OUT_READY = 1'b0;
    chk(all_zero(), {j.name, "/idle_after_ready"}, out_str());
  endtask

  job_t tbl[9];
  job_t rj;
  bit   reached, rdy_bad;

  initial begin
    tbl[0] = '{64'd4,   64'd1,   64'd10, 64'd10, 0,  0,  1'b0, 4,  4,    "basic"};
    tbl[1] = '{64'd3,   64'd2,   64'd5,  64'd1,  0,  0,  1'b0, 3,  6,    "replay"};
    tbl[2] = '{64'd5,   64'd2,   64'd0,  64'd0,  40, 0,  1'b1, 5,  10,   "gaps_stall"};
    tbl[3] = '{64'd6,   64'd3,   64'd0,  64'd0,  40, 40, 1'b0, 6,  18,   "gaps_bp"};
    tbl[4] = '{64'd0,   64'd3,   64'd0,  64'd0,  0,  0,  1'b0, 0,  0,    "zero_x"};
    tbl[5] = '{64'd4,   64'd0,   64'd0,  64'd0,  0,  0,  1'b0, 0,  0,    "zero_l"};
    tbl[6] = '{64'd100, 64'd1,   64'd0,  64'd0,  0,  0,  1'b0, 64, 64,   "clamp_x"};
    tbl[7] = '{64'd1,   64'd3,   64'd7,  64'd0,  0,  0,  1'b0, 1,  3,    "one_x"};
    tbl[8] = '{64'hFFFF_FFFF_0000_0005, 64'd70, 64'd0, 64'd0, 10, 10, 1'b0, 64, 4096, "clamp_both"};

    // Reset held 2 cycles with START and host traffic active
    rst = 1'b1;
    bus.START = 1'b1; bus.SIZE_X_IN = 64'd4; bus.SIZE_L_IN = 64'd1;
    bus.X_IN_ENABLE = 1'b1; bus.X_IN = 64'd99; bus.X_OUT_READY = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk(all_zero(), $sformatf("reset_state_%0d", c), out_str());
    end
    rst = 1'b0; bus.START = 1'b0; bus.X_IN_ENABLE = 1'b0; bus.X_OUT_READY = 1'b0;
    @(negedge clk);
    chk(all_zero(), "idle_after_reset", out_str());

    for (int t = 0; t < 9; t++) run_job(tbl[t]);

    // Random jobs against the model
    for (int r = 0; r < 6; r++) begin
      rj.sx = 64'($urandom_range(1, 20));
      rj.sl = 64'($urandom_range(1, 4));
      rj.base = 64'd0; rj.step = 64'd0;
      rj.gap = 30; rj.bp = 30; rj.stall = 1'b0;
      rj.exp_acc = int'(rj.sx); rj.exp_out = int'(rj.sx * rj.sl);
      rj.name = $sformatf("rand%0d", r);
      run_job(rj);
    end

    // Reset in the middle of the second replay
    @(negedge clk);
    bus.START = 1'b1; bus.SIZE_X_IN = 64'd3; bus.SIZE_L_IN = 64'd3;
    reached = 1'b0;
    for (int c = 0; c < 200 && !reached; c++) begin
      @(negedge clk);
      bus.START = 1'b0;
      if (bus.X_OUT_ENABLE && bus.L_OUT_INDEX == 64'd1) reached = 1'b1;
      else begin
        bus.X_IN_ENABLE = bus.X_IN_ACCEPT; bus.X_IN = 64'(c + 100);
        bus.X_OUT_READY = 1'b1;
      end
    end
    chk(reached, "mid_stream_reached", "L_OUT_INDEX never reached 1");
    rst = 1'b1;
    @(negedge clk);
    chk(all_zero(), "reset_mid_stream", out_str());
    rst = 1'b0; bus.X_IN_ENABLE = 1'b0; bus.X_OUT_READY = 1'b1;
    rdy_bad = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (!all_zero()) rdy_bad = 1'b1;
    end
    chk(!rdy_bad, "abandoned_job_quiet", out_str());
    bus.X_OUT_READY = 1'b0;
    run_job('{64'd3, 64'd2, 64'd0, 64'd0, 20, 20, 1'b0, 3, 6, "after_reset"});

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
